// File: rtl/npc_core_if.sv
// npc_core_if: commit/observation bundle of the npc_core processor.
//   commit_valid   one-cycle pulse per retired instruction
//   commit_pc      PC of the retiring instruction
//   commit_inst    encoding of the retiring instruction
//   commit_is_end  retiring instruction is ebreak
//   halted         core has stopped (sticky until reset)
//   halt_code      a0 at the halting retire (all ones on an illegal-instruction trap)
// modport master: driven by the core; modport slave: observer (bench, difftest).
interface npc_core_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_is_end;
    logic        halted;
    logic [31:0] halt_code;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_is_end, halted, halt_code
    );
    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_is_end, halted, halt_code
    );
endinterface

// File: rtl/npc_core.sv
// npc_core: minimal multicycle RV32E core with a unified, tightly coupled
// instruction/data memory (synchronous read, byte-enable write).
//   clock   system clock, all state changes on the rising edge
//   reset   asynchronous, active-low
//   commit  npc_core_if.master, retire/halt observation outputs
// One FSM state per cycle: IF, ID, EX, [MEM], WB; ebreak parks the core in HALT.
// Optional build macro ILLEGAL_INST_TRAP_EN: unknown encodings or register
// indices >= 16 halt the core with halt_code = all ones. Without it, unknown
// encodings retire as NOPs and register index bit 4 is ignored.
// MEM_WORDS is expected to be a power of two (address wraps by truncation).
module npc_core #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 4194304
) (
    input  logic       clock,
    input  logic       reset,
    npc_core_if.master commit
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
`ifdef ILLEGAL_INST_TRAP_EN
    localparam logic [6:0] OP_FENCE  = 7'h0f;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
`endif
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    state_t state, state_nx;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] mem_rdata;
    logic [31:0] rf [16];            // rf[0] is never written, so it always reads 0

    logic [31:0] pc, ir, a_q, b_q, res_q, npc_q, addr_q, halt_q;
    logic        wen_q, ld_q, st_q, end_q, ill_q;

    // ---------------- decode fields of the latched instruction ----------------
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = ir[6:0];
    assign f3    = ir[14:12];
    assign rd    = ir[10:7];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // ---------------- memory ----------------
    // The address mux selects the data address only in MEM; otherwise the PC,
    // so the word read during IF is the instruction seen in ID.
    logic [31:0]   mem_addr;
    logic [AW-1:0] mem_idx;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign mem_addr = (state == S_MEM) ? addr_q : pc;
    assign mem_idx  = AW'((mem_addr - MEM_BASE) >> 2);

    always_comb begin
        st_be   = 4'b1111;
        st_data = b_q;
        case (f3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << addr_q[1:0];
                st_data = {4{b_q[7:0]}};
            end
            2'b01: begin
                st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{b_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Reset forces state to IF asynchronously, so no store can fire while
    // reset is held; memory contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (state == S_MEM && st_q) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i]) mem[mem_idx][i*8 +: 8] <= st_data[i*8 +: 8];
        end
        mem_rdata <= mem[mem_idx];
    end

    // ---------------- EX: ALU, branch, effective address ----------------
    logic [31:0] op2, alu, ex_res, ex_npc, ex_addr;
    logic        take, ex_wen, ex_mem, ex_ill;

    always_comb begin
        op2 = (opc == OP_OP) ? b_q : imm_i;
        case (f3)
            3'd0:    alu = (opc == OP_OP && ir[30]) ? a_q - op2 : a_q + op2;
            3'd1:    alu = a_q << op2[4:0];
            3'd2:    alu = {31'b0, $signed(a_q) < $signed(op2)};
            3'd3:    alu = {31'b0, a_q < op2};
            3'd4:    alu = a_q ^ op2;
            3'd5:    alu = ir[30] ? 32'($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
            3'd6:    alu = a_q | op2;
            default: alu = a_q & op2;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    take = (a_q == b_q);
            3'd1:    take = (a_q != b_q);
            3'd4:    take = ($signed(a_q) <  $signed(b_q));
            3'd5:    take = ($signed(a_q) >= $signed(b_q));
            3'd6:    take = (a_q <  b_q);
            3'd7:    take = (a_q >= b_q);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        ex_res  = alu;
        ex_npc  = pc + 32'd4;
        ex_wen  = 1'b0;
        ex_addr = a_q + imm_i;
        case (opc)
            OP_LUI:    begin ex_res = imm_u;      ex_wen = 1'b1; end
            OP_AUIPC:  begin ex_res = pc + imm_u; ex_wen = 1'b1; end
            OP_JAL: begin
                ex_res = pc + 32'd4;
                ex_npc = pc + imm_j;
                ex_wen = 1'b1;
            end
            OP_JALR: begin
                ex_res = pc + 32'd4;
                ex_npc = (a_q + imm_i) & 32'hFFFF_FFFE;
                ex_wen = 1'b1;
            end
            OP_BRANCH: if (take) ex_npc = pc + imm_b;
            OP_LOAD:   ex_wen = 1'b1;
            OP_STORE:  ex_addr = a_q + imm_s;
            OP_IMM, OP_OP: ex_wen = 1'b1;
            default: ;   // fence, ecall, unknown: plain pc+4
        endcase
    end

`ifdef ILLEGAL_INST_TRAP_EN
    // Register-index checks apply only to the fields the format actually uses.
    logic       known, use_rd, use_rs1, use_rs2;
    logic [6:0] f7;
    assign f7 = ir[31:25];

    always_comb begin
        known   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: begin known = 1'b1; use_rd = 1'b1; end
            OP_JALR:   begin known = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_BRANCH: begin known = (f3 != 3'd2 && f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LOAD:   begin known = (f3 != 3'd3 && f3 <= 3'd5); use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_STORE:  begin known = (f3 <= 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                if (f3 == 3'd1)      known = (f7 == 7'h00);
                else if (f3 == 3'd5) known = (f7 == 7'h00 || f7 == 7'h20);
                else                 known = 1'b1;
            end
            OP_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                known   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            OP_FENCE:  known = 1'b1;
            OP_SYSTEM: known = (ir == EBREAK) || (ir == 32'h0000_0073);
            default:   known = 1'b0;
        endcase
    end

    assign ex_ill = !known || (use_rd && ir[11]) || (use_rs1 && ir[19]) || (use_rs2 && ir[24]);
`else
    assign ex_ill = 1'b0;
`endif

    assign ex_mem = (opc == OP_LOAD || opc == OP_STORE) && !ex_ill;

    // ---------------- WB: load extraction ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val, wb_data, halt_val;
    logic        wb, halt_now;

    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (f3)
            3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_val = {24'b0, ld_byte};
            3'd5:    ld_val = {16'b0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    assign wb_data  = ld_q ? ld_val : res_q;
    assign wb       = (state == S_WB);
    assign halt_now = wb && (end_q || ill_q);
    assign halt_val = ill_q ? 32'hFFFF_FFFF : rf[10];

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IF;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IF:    state_nx = S_ID;
            S_ID:    state_nx = S_EX;
            S_EX:    state_nx = ex_mem ? S_MEM : S_WB;
            S_MEM:   state_nx = S_WB;
            S_WB:    state_nx = (end_q || ill_q) ? S_HALT : S_IF;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IF;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            npc_q  <= '0;
            addr_q <= '0;
            halt_q <= '0;
            wen_q  <= 1'b0;
            ld_q   <= 1'b0;
            st_q   <= 1'b0;
            end_q  <= 1'b0;
            ill_q  <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_ID: begin
                    ir  <= mem_rdata;
                    a_q <= rf[mem_rdata[18:15]];
                    b_q <= rf[mem_rdata[23:20]];
                end
                S_EX: begin
                    res_q  <= ex_res;
                    npc_q  <= ex_npc;
                    addr_q <= ex_addr;
                    wen_q  <= ex_wen && !ex_ill;
                    ld_q   <= (opc == OP_LOAD)  && !ex_ill;
                    st_q   <= (opc == OP_STORE) && !ex_ill;
                    end_q  <= (ir == EBREAK);
                    ill_q  <= ex_ill;
                end
                S_WB: begin
                    if (wen_q && rd != 4'd0) rf[rd] <= wb_data;
                    pc <= npc_q;
                    if (halt_now) halt_q <= halt_val;
                end
                default: ;
            endcase
        end
    end

    // ---------------- observation outputs ----------------
    // Decoded from state so they drop to zero the instant reset asserts,
    // and halted/halt_code are already visible in the halting WB cycle.
    assign commit.commit_valid  = wb;
    assign commit.commit_pc     = wb ? pc : 32'd0;
    assign commit.commit_inst   = wb ? ir : 32'd0;
    assign commit.commit_is_end = wb && end_q;
    assign commit.halted        = halt_now || (state == S_HALT);
    assign commit.halt_code     = (state == S_HALT) ? halt_q : (halt_now ? halt_val : 32'd0);
endmodule

// File: tb/tb_npc_core.sv
module tb_npc_core;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          MW     = 65536;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int          DIDX   = 32'h4000;   // word index of 0x8001_0000

    logic clock;
    logic reset;
    npc_core_if bus();

    npc_core #(.RESET_PC(BASE), .MEM_BASE(BASE), .MEM_WORDS(MW)) dut (
        .clock (clock),
        .reset (reset),
        .commit(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk, n_err;
    int ncom;
    logic [31:0] cpcs [$];

    // ISA-level reference state
    logic [31:0] mx [16];
    logic [31:0] mpc;
    logic [31:0] mm [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] e_i(int op, int f3, int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_s(int f3, int rs2, int rs1, int imm);
        logic [11:0] v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(int f3, int rs1, int rs2, int imm);
        logic [12:0] v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(int op, int rd, int imm20);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] e_j(int rd, int imm);
        logic [20:0] v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction

    // ---------------- reference memory ----------------
    function automatic int widx(logic [31:0] a);
        return int'(((a - BASE) >> 2) & (MW - 1));
    endfunction
    function automatic logic [31:0] mrd(logic [31:0] a);
        int k = widx(a);
        return mm.exists(k) ? mm[k] : 32'd0;
    endfunction
    task automatic put(input int idx, input logic [31:0] w);
        dut.mem[idx] = w;
        mm[idx] = w;
    endtask

    function automatic logic [31:0] m_alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa = a;
        logic signed [31:0] sb = b;
        int sh = int'(b & 32'h1f);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Executes one instruction architecturally; lat is the expected cycle count.
    task automatic m_step(output logic [31:0] ipc, output logic [31:0] inst,
                          output logic is_end, output int lat);
        logic [31:0] a, b, ii, is, ib, iu, ij, nx, wv, ad, w;
        logic signed [31:0] sa, sb;
        logic [3:0] rd;
        logic [2:0] f3;
        logic wr, tk;
        int k;
        inst = mrd(mpc);
        ipc  = mpc;
        rd   = inst[10:7];
        f3   = inst[14:12];
        a    = mx[inst[18:15]];
        b    = mx[inst[23:20]];
        sa   = a;
        sb   = b;
        ii   = {{20{inst[31]}}, inst[31:20]};
        is   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ib   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        iu   = {inst[31:12], 12'b0};
        ij   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        nx   = mpc + 4;
        wv   = 0;
        wr   = 0;
        lat  = 4;
        is_end = (inst == EBREAK);
        case (inst[6:0])
            7'h37: begin wv = iu; wr = 1; end
            7'h17: begin wv = mpc + iu; wr = 1; end
            7'h6f: begin wv = mpc + 4; wr = 1; nx = mpc + ij; end
            7'h67: begin wv = mpc + 4; wr = 1; nx = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (sa < sb);
                    3'd5: tk = (sa >= sb);
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) nx = mpc + ib;
            end
            7'h03: begin
                lat = 5;
                wr  = 1;
                ad  = a + ii;
                w   = mrd(ad);
                k   = int'(ad[1:0]);
                case (f3)
                    3'd0: wv = 32'($signed(8'(w >> (8 * k))));
                    3'd1: wv = 32'($signed(ad[1] ? w[31:16] : w[15:0]));
                    3'd4: wv = 32'(8'(w >> (8 * k)));
                    3'd5: wv = {16'd0, ad[1] ? w[31:16] : w[15:0]};
                    default: wv = w;
                endcase
            end
            7'h23: begin
                lat = 5;
                ad  = a + is;
                w   = mrd(ad);
                k   = int'(ad[1:0]);
                case (f3)
                    3'd0: w[8*k +: 8] = b[7:0];
                    3'd1: if (ad[1]) w[31:16] = b[15:0]; else w[15:0] = b[15:0];
                    default: w = b;
                endcase
                mm[widx(ad)] = w;
            end
            7'h13: begin wr = 1; wv = m_alu(f3, f3 == 3'd5 && inst[30], a, ii); end
            7'h33: begin wr = 1; wv = m_alu(f3, inst[30], a, b); end
            default: ;
        endcase
        if (wr && rd != 0) mx[rd] = wv;
        mpc = nx;
    endtask

    // Reset, run until the ebreak retire, and compare every commit with the model.
    task automatic run_prog(input int budget);
        logic [31:0] epc, einst;
        logic eend;
        int lat, last, cyc, extra;
        bit done;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", {31'd0, bus.commit_valid}, 0);
        chk("rst_pc", bus.commit_pc, 0);
        chk("rst_inst", bus.commit_inst, 0);
        chk("rst_end", {31'd0, bus.commit_is_end}, 0);
        chk("rst_halted", {31'd0, bus.halted}, 0);
        chk("rst_code", bus.halt_code, 0);
        for (int i = 0; i < 16; i++) mx[i] = 0;
        mpc  = BASE;
        ncom = 0;
        cpcs.delete();
        reset = 1'b1;
        last = -1;
        cyc  = 0;
        done = 0;
        while (!done && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (bus.commit_valid) begin
                m_step(epc, einst, eend, lat);
                chk("commit_pc", bus.commit_pc, epc);
                chk("commit_inst", bus.commit_inst, einst);
                chk("commit_end", {31'd0, bus.commit_is_end}, {31'd0, eend});
                chk("commit_halted", {31'd0, bus.halted}, {31'd0, eend});
                chk($sformatf("gap@%h", epc), cyc - last, lat);
                cpcs.push_back(bus.commit_pc);
                ncom++;
                last = cyc;
                if (eend) begin
                    done = 1;
                    chk("halt_code", bus.halt_code, mx[10]);
                end
            end
        end
        if (!done) chk("timeout_no_end", 0, 1);
        extra = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.commit_valid) extra++;
        end
        chk("commits_after_halt", extra, 0);
        chk("halted_sticky", {31'd0, bus.halted}, {31'd0, done});
        for (int i = 1; i < 16; i++) chk($sformatf("x%0d", i), dut.rf[i], mx[i]);
    endtask

    function automatic logic [31:0] rnd_inst();
        int k   = $urandom_range(0, 9);
        int rd  = $urandom_range(0, 14);   // x15 stays the data base
        int rs1 = $urandom_range(0, 15);
        int rs2 = $urandom_range(0, 15);
        int f3  = $urandom_range(0, 7);
        int sel;
        case (k)
            0, 1: begin
                if (f3 == 1)      return e_i(7'h13, 1, rd, rs1, $urandom_range(0, 31));
                else if (f3 == 5) return e_i(7'h13, 5, rd, rs1, $urandom_range(0, 31) | ($urandom_range(0, 1) << 10));
                else              return e_i(7'h13, f3, rd, rs1, $urandom_range(0, 4095));
            end
            2, 3: return e_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 0, rs2, rs1, f3, rd);
            4: return e_u($urandom_range(0, 1) == 1 ? 7'h37 : 7'h17, rd, $urandom);
            5, 9: begin
                sel = $urandom_range(0, 4);
                return e_i(7'h03, (sel == 3) ? 4 : (sel == 4) ? 5 : sel, rd, 15, $urandom_range(0, 255));
            end
            6: return e_s($urandom_range(0, 2), rs2, 15, $urandom_range(0, 255));
            7: begin
                sel = $urandom_range(0, 5);
                return e_b((sel < 2) ? sel : sel + 2, rs1, rs2, 8);
            end
            default: return e_j(rd, 8);
        endcase
    endfunction

    int seen;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;

        // T1: addi a0,5; ebreak
        mm.delete();
        put(0, e_i(7'h13, 0, 10, 0, 5));
        put(1, EBREAK);
        run_prog(200);
        chk("t1_commits", ncom, 2);
        chk("t1_pc0", cpcs[0], 32'h8000_0000);
        chk("t1_pc1", cpcs[1], 32'h8000_0004);
        chk("t1_code", bus.halt_code, 5);
        reset = 1'b0;
        #1;
        chk("t1_async_halted", {31'd0, bus.halted}, 0);
        chk("t1_async_code", bus.halt_code, 0);

        // T2: byte store/load with neighbouring bytes preserved
        mm.delete();
        put(DIDX, 32'h1122_3344);
        put(0, e_u(7'h37, 2, 32'h80010));
        put(1, e_i(7'h13, 0, 1, 0, -1));
        put(2, e_s(0, 1, 2, 1));
        put(3, e_i(7'h03, 0, 3, 2, 1));
        put(4, e_i(7'h03, 4, 4, 2, 1));
        put(5, EBREAK);
        run_prog(200);
        chk("t2_lb", dut.rf[3], 32'hFFFF_FFFF);
        chk("t2_lbu", dut.rf[4], 32'h0000_00FF);
        chk("t2_word", dut.mem[DIDX], 32'h1122_FF44);

        // T3: count loop to 10
        mm.delete();
        put(0, e_i(7'h13, 0, 6, 0, 10));
        put(1, e_i(7'h13, 0, 5, 5, 1));
        put(2, e_b(1, 5, 6, -4));
        put(3, e_i(7'h13, 0, 10, 5, 0));
        put(4, EBREAK);
        run_prog(400);
        chk("t3_code", bus.halt_code, 10);
        chk("t3_commits", ncom, 23);

        // T4: jal at 0x10, jalr through an odd register
        mm.delete();
        for (int i = 0; i < 4; i++) put(i, e_i(7'h13, 0, 0, 0, 0));
        put(4, e_j(1, 8));
        put(5, e_i(7'h13, 0, 10, 0, 99));
        put(6, e_i(7'h13, 0, 8, 1, 32'h11));
        put(7, e_i(7'h67, 0, 0, 8, 0));
        put(8, EBREAK);
        put(9, e_i(7'h13, 0, 10, 0, 7));
        put(10, EBREAK);
        run_prog(200);
        chk("t4_link", dut.rf[1], 32'h8000_0014);
        chk("t4_after_jal", cpcs[5], 32'h8000_0018);
        chk("t4_after_jalr", cpcs[7], 32'h8000_0024);
        chk("t4_code", bus.halt_code, 7);

        // T5: shifts and compares against 0x8000_0000
        mm.delete();
        put(0, e_u(7'h37, 1, 32'h80000));
        put(1, e_i(7'h13, 0, 2, 0, 1));
        put(2, e_i(7'h13, 5, 3, 1, 32'h404));
        put(3, e_i(7'h13, 5, 4, 1, 4));
        put(4, e_r(0, 1, 2, 3, 5));
        put(5, e_r(0, 1, 2, 2, 6));
        put(6, EBREAK);
        run_prog(200);
        chk("t5_sra", dut.rf[3], 32'hF800_0000);
        chk("t5_srl", dut.rf[4], 32'h0800_0000);
        chk("t5_sltu", dut.rf[5], 1);
        chk("t5_slt", dut.rf[6], 0);

        // T6: reset asserted during EX of addi x7
        mm.delete();
        put(0, e_i(7'h13, 0, 7, 0, 9));
        put(1, EBREAK);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_valid", {31'd0, bus.commit_valid}, 0);
        chk("t6_pc", bus.commit_pc, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.commit_valid) seen++;
        end
        chk("t6_no_commit", seen, 0);
        chk("t6_x7", dut.rf[7], 0);
        run_prog(200);
        chk("t6_first_pc", cpcs[0], 32'h8000_0000);

        // Random programs: forward-only control flow, double ebreak at the end
        for (int p = 0; p < 20; p++) begin
            mm.delete();
            for (int j = 0; j < 64; j++) put(DIDX + j, $urandom);
            put(0, e_u(7'h37, 15, 32'h80010));
            for (int i = 1; i <= 25; i++) put(i, rnd_inst());
            put(26, EBREAK);
            put(27, EBREAK);
            run_prog(600);
            for (int j = 0; j < 64; j++) chk($sformatf("p%0d_mem%0d", p, j), dut.mem[DIDX + j], mm[DIDX + j]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/npc_core.md
Name: npc_core

Overview:
- Minimal multicycle RV32E processor core with a tightly coupled unified instruction/data memory.
- Top-level simulation target: the bench drives only clock and reset, preloads the memory array hierarchically, and waits for a retire carrying the end flag (ebreak).
- Exposes a commit/observation interface for benches and difftest.

Parameters:
- RESET_PC, 32'h8000_0000, address of the first fetch after reset.
- MEM_BASE, 32'h8000_0000, byte address mapped to memory word 0.
- MEM_WORDS, 4194304, number of 32-bit memory words (16 MiB); word index = ((addr - MEM_BASE) >> 2) mod MEM_WORDS.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- commit_valid  out  1  one-cycle pulse when an instruction retires.
- commit_pc  out  32  PC of the retiring instruction; valid with commit_valid.
- commit_inst  out  32  encoding of the retiring instruction.
- commit_is_end  out  1  retiring instruction is ebreak; valid with commit_valid.
- halted  out  1  core stopped after ebreak (or trap); sticky until reset.
- halt_code  out  32  value of x10 (a0) captured at the halting retire.

Behaviour:
- Reset (reset==0, async):
  - pc=RESET_PC, FSM=IF, x1..x15=0.
  - commit_valid=0, commit_pc=0, commit_inst=0, commit_is_end=0, halted=0, halt_code=0.
  - Memory contents are not cleared.
  - Reset mid-instruction abandons it; no partial register write. A store whose MEM cycle has already completed remains in memory.
- Memory: word array, synchronous read with 1-cycle latency, synchronous write with 4-bit byte enables. Address bits [1:0] select bytes/halves only.
- FSM, one state per cycle:
  - IF: present pc to memory.
  - ID: latch instruction; read rs1/rs2 combinationally.
  - EX: ALU, branch decision, effective address. Loads/stores go to MEM; all others go to WB.
  - MEM: store writes with byte enables; load issues read.
  - WB: write rd, update pc, pulse commit_valid, return to IF.
  - HALT: absorbing; no fetch, no commits.
- Latency: 4 cycles for non-memory instructions, 5 cycles for loads/stores. Exactly one commit per instruction.
- ISA: RV32I base integer set minus fence/CSR, on 16 registers.
  - Supported: lui, auipc, jal, jalr, beq/bne/blt/bge/bltu/bgeu, lb/lh/lw/lbu/lhu, sb/sh/sw, and all OP-IMM and OP ALU operations.
  - x0 reads 0; writes to x0 are discarded.
  - Shifts use shamt[4:0]; sra/srai are arithmetic. slt is signed, sltu unsigned.
  - jalr target = (rs1+imm) & ~1; link value = pc+4. Branch/jal target = pc+imm.
  - All arithmetic wraps modulo 2^32.
- Loads: lb/lh sign-extend, lbu/lhu zero-extend. Halfword lane is selected by addr[1]; addr[0] is ignored for halves. lw ignores addr[1:0].
- Stores: sb replicates the byte to all lanes with a one-hot enable. sh uses enable 0011 or 1100 by addr[1]. sw uses 1111.
- Misaligned control-flow targets are not checked.
- ebreak (32'h0010_0073):
  - Retires with commit_valid=1 and commit_is_end=1 in its WB cycle.
  - halted rises in that same cycle; halt_code=x10.
  - FSM then enters HALT.
- ecall and fence retire as NOP (pc+4).

Optional Feature:
- Macro ILLEGAL_INST_TRAP_EN.
- Defined:
  - An unknown opcode/funct combination, or any rd/rs1/rs2 index >= 16, counts as illegal.
  - An illegal instruction retires with commit_is_end=0, sets halted=1 and halt_code=32'hFFFF_FFFF, and enters HALT.
- Undefined:
  - Unknown encodings retire as NOP (pc+4).
  - Register index bit 4 is ignored, so x16..x31 alias x0..x15.

Test Plan:
- Release reset with memory holding addi x10,x0,5; ebreak at 0x8000_0000 -> commits at pc 8000_0000 then 8000_0004; second commit has commit_is_end=1; halted=1; halt_code=5; no further commits.
- li x1,-1; sb x1,0(x2); lb x3; lbu x4 (x2 = data addr) -> x3=FFFF_FFFF, x4=0000_00FF; other bytes of the word unchanged; load/store commits spaced 5 cycles, ALU ops 4 cycles.
- Count loop: addi x5,x5,1; bne x5,x6 (x6=10), then a0=x5; ebreak -> halt_code=10; commit_valid is high exactly once per 4-cycle instruction.
- jal x1,+8 at 8000_0010 -> x1=8000_0014, next commit_pc=8000_0018; jalr x0,0(x1) with x1 odd -> target bit 0 cleared.
- sra/srl/sltu/slt with x1=8000_0000, shamt 4 -> F800_0000 / 0800_0000; sltu(1,x1)=1; slt(1,x1)=0.
- Drive reset low in the EX of an addi to x7 -> x7 stays 0; outputs return to reset values immediately (async); after release the first commit_pc is 8000_0000.
